// File: rtl/seg7_scan.sv
// Eight-digit multiplexed 7-segment scanner with a per-frame shadow register.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_lane (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  logic [6:0] dec;

  always_comb begin
    dec = 7'h7F;
    case (nib)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      4'hF: dec = 7'h0E;
      default: dec = 7'h7F;
    endcase
  end

  assign seg = blank ? 7'h7F : dec;
endmodule

module seg7_scan #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic        freeze_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        frame_o
);
  localparam int NUM_DIGITS = 8;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0]                 cnt;
  logic [2:0]                    idx;
  logic [31:0]                   shadow;
  logic                          tick;
  logic                          load_pt;
  logic [NUM_DIGITS-1:0]         blank;
  logic [NUM_DIGITS-1:0][6:0]    lane_seg;

  assign tick    = (cnt == CW'(CLK_DIV - 1));
  assign load_pt = tick && (idx == 3'd7);

`ifdef SEG7_LZ_BLANK_EN
  // Digit i goes dark when it and every digit to its left are zero.
  always_comb begin
    blank = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      blank[i] = ((shadow >> (4 * i)) == 32'd0);
  end
`else
  assign blank = '0;
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    seg7_lane u_lane (
      .nib   (shadow[4*g +: 4]),
      .blank (blank[g]),
      .seg   (lane_seg[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 3'd1;
      if (load_pt && !freeze_i) shadow <= data_i;
    end
  end

  // Outputs follow the pre-edge index/shadow, so the new shadow first
  // appears one cycle after the load, in the digit 0 slot.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      an_o    <= 8'hFF;
      seg_o   <= 7'h7F;
      frame_o <= 1'b0;
    end else begin
      an_o    <= blank[idx] ? 8'hFF : ~(8'h01 << idx);
      seg_o   <= lane_seg[idx];
      frame_o <= load_pt;
    end
  end
endmodule
